// File: rtl/generator_arbiter.sv
// Round-robin arbiter that shares one start/done style generator between two requesters.
// Latches the winner's arguments, pulses gen_start, forwards outputs, and aborts stalled runs.
module generator_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic [1:0]              req_start,
    input  logic [4*WIDTH-1:0]      req0_args,
    input  logic [4*WIDTH-1:0]      req1_args,
    output logic [1:0]              req_ack,
    output logic signed [WIDTH-1:0] rsp_out0,
    output logic signed [WIDTH-1:0] rsp_out1,
    output logic [1:0]              rsp_valid,
    output logic [1:0]              rsp_done,
    output logic                    rsp_err,
    output logic                    gen_start,
    output logic                    gen_reset,
    output logic signed [WIDTH-1:0] gen_a,
    output logic signed [WIDTH-1:0] gen_b,
    output logic signed [WIDTH-1:0] gen_c,
    output logic signed [WIDTH-1:0] gen_d,
    input  logic signed [WIDTH-1:0] gen_out0,
    input  logic signed [WIDTH-1:0] gen_out1,
    input  logic                    gen_valid,
    input  logic                    gen_done
);

    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, RUN, FINISH} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;
    logic [WDW-1:0]          wd_q, wd_d;
    logic [4*WIDTH-1:0]      args_q, args_d;
    logic signed [WIDTH-1:0] hold0_q, hold0_d;
    logic signed [WIDTH-1:0] hold1_q, hold1_d;
    logic                    win;
    logic                    fwd;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        err_d     = err_q;
        wd_d      = wd_q;
        args_d    = args_q;
        hold0_d   = hold0_q;
        hold1_d   = hold1_q;
        req_ack   = '0;
        rsp_valid = '0;
        rsp_done  = '0;
        rsp_err   = 1'b0;
        gen_start = 1'b0;
        gen_reset = 1'b0;
        fwd       = 1'b0;
        // On a tie the requester that was not served last wins.
        win       = (req_start == 2'b11) ? ~last_q : req_start[1];

        // Combinational outputs are suppressed while reset is asserted.
        if (!_reset) begin
            unique case (state_q)
                IDLE: begin
                    if (|req_start) begin
                        owner_d      = win;
                        args_d       = win ? req1_args : req0_args;
                        req_ack[win] = 1'b1;
                        state_d      = START;
                    end
                end
                START: begin
                    gen_start = 1'b1;
                    wd_d      = '0;
                    state_d   = RUN;
                end
                RUN: begin
                    fwd                = gen_valid;
                    rsp_valid[owner_q] = gen_valid;
                    if (gen_valid) begin
                        hold0_d = gen_out0;
                        hold1_d = gen_out1;
                    end
                    wd_d = (gen_valid || gen_done) ? '0 : wd_q + 1'b1;
                    if (gen_done) begin
                        err_d   = 1'b0;
                        state_d = FINISH;
                    end else if (!gen_valid && wd_q == WD_LAST) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end
                end
                FINISH: begin
                    rsp_done[owner_q] = 1'b1;
                    rsp_err           = err_q;
                    gen_reset         = err_q;
                    last_d            = owner_q;
                    state_d           = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rsp_out0 = _reset ? '0 : (fwd ? gen_out0 : hold0_q);
    assign rsp_out1 = _reset ? '0 : (fwd ? gen_out1 : hold1_q);
    assign gen_a    = args_q[WIDTH-1:0];
    assign gen_b    = args_q[2*WIDTH-1:WIDTH];
    assign gen_c    = args_q[3*WIDTH-1:2*WIDTH];
    assign gen_d    = args_q[4*WIDTH-1:3*WIDTH];

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            wd_q    <= '0;
            args_q  <= '0;
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            args_q  <= args_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
        end
    end

endmodule

// File: tb/tb_generator_arbiter.sv
// Directed bench for generator_arbiter: grants, forwarding, fairness, watchdog abort and reset.
// Expected responses are queued when generator outputs are driven and popped when rsp_valid fires.
module tb_generator_arbiter;

    localparam int W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_start;
    logic [4*W-1:0]       req0_args, req1_args;
    logic [1:0]           req_ack, rsp_valid, rsp_done;
    logic signed [W-1:0]  rsp_out0, rsp_out1;
    logic                 rsp_err, gen_start, gen_reset;
    logic signed [W-1:0]  gen_a, gen_b, gen_c, gen_d;
    logic signed [W-1:0]  gen_out0, gen_out1;
    logic                 gen_valid, gen_done;

    typedef struct {
        logic [1:0]   v;
        logic [W-1:0] o0;
        logic [W-1:0] o1;
    } rsp_t;

    rsp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [4*W-1:0] ARGS0 = {16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [4*W-1:0] ARGS1 = {16'd8, 16'd7, 16'd6, 16'd5};

    generator_arbiter #(.WIDTH(W), .TIMEOUT(8)) dut (
        ._clock   (clk),
        ._reset   (rst),
        .req_start(req_start),
        .req0_args(req0_args),
        .req1_args(req1_args),
        .req_ack  (req_ack),
        .rsp_out0 (rsp_out0),
        .rsp_out1 (rsp_out1),
        .rsp_valid(rsp_valid),
        .rsp_done (rsp_done),
        .rsp_err  (rsp_err),
        .gen_start(gen_start),
        .gen_reset(gen_reset),
        .gen_a    (gen_a),
        .gen_b    (gen_b),
        .gen_c    (gen_c),
        .gen_d    (gen_d),
        .gen_out0 (gen_out0),
        .gen_out1 (gen_out1),
        .gen_valid(gen_valid),
        .gen_done (gen_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample point: every rsp_valid seen here must match the oldest queued response.
    task automatic at_neg();
        rsp_t e;
        @(negedge clk);
        if (rsp_valid !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("sb_spurious_valid", 64'(rsp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_valid", 64'(rsp_valid), 64'(e.v));
                chk("sb_out0", 64'(rsp_out0), 64'(e.o0));
                chk("sb_out1", 64'(rsp_out1), 64'(e.o1));
            end
        end
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, 64'({req_ack, rsp_valid, rsp_done, rsp_err, gen_start, gen_reset}), 64'd0);
        chk({tag, "_args"}, 64'({gen_d, gen_c, gen_b, gen_a}), 64'd0);
        chk({tag, "_outs"}, 64'({rsp_out1, rsp_out0}), 64'd0);
    endtask

    // One full grant: request, START, nv valid beats, done, FINISH.
    task automatic txn(input logic [1:0] req, input int owner, input logic [4*W-1:0] exp_args,
                       input int nv, input logic [W-1:0] base, input bit done_same, input bit hold);
        logic [1:0] ob;
        ob = (owner == 1) ? 2'b10 : 2'b01;
        req_start = req;
        at_neg();
        chk("grant_ack", 64'(req_ack), 64'(ob));
        chk("grant_nostart", 64'(gen_start), 64'd0);
        to_next();
        if (!hold) req_start = 2'b00;
        at_neg();
        chk("start_pulse", 64'(gen_start), 64'd1);
        chk("start_args", 64'({gen_d, gen_c, gen_b, gen_a}), 64'(exp_args));
        chk("start_noack", 64'(req_ack), 64'd0);
        to_next();
        for (int i = 0; i < nv; i++) begin
            gen_valid = 1'b1;
            gen_out0  = base + W'(2 * i);
            gen_out1  = base + W'(2 * i + 1);
            gen_done  = done_same && (i == nv - 1);
            sb.push_back('{v: ob, o0: gen_out0, o1: gen_out1});
            at_neg();
            chk("sb_drained", 64'(sb.size()), 64'd0);
            chk("run_nostart", 64'(gen_start), 64'd0);
            to_next();
        end
        if (!done_same) begin
            gen_valid = 1'b0;
            gen_done  = 1'b1;
            at_neg();
            chk("done_not_yet", 64'(rsp_done), 64'd0);
            to_next();
        end
        gen_valid = 1'b0;
        gen_done  = 1'b0;
        at_neg();
        chk("finish_done", 64'(rsp_done), 64'(ob));
        chk("finish_err", 64'(rsp_err), 64'd0);
        chk("finish_genrst", 64'(gen_reset), 64'd0);
        chk("finish_noack", 64'(req_ack), 64'd0);
        to_next();
    endtask

    initial begin
        rst       = 1'b1;
        req_start = 2'b00;
        req0_args = ARGS0;
        req1_args = ARGS1;
        gen_out0  = '0;
        gen_out1  = '0;
        gen_valid = 1'b0;
        gen_done  = 1'b0;
        to_next();
        to_next();
        at_neg();
        chk_quiet("reset");
        to_next();
        rst = 1'b0;

        // Outputs presented while idle must be ignored.
        gen_valid = 1'b1;
        gen_out0  = 16'd55;
        at_neg();
        chk("idle_ignore_valid", 64'(rsp_valid), 64'd0);
        to_next();
        gen_valid = 1'b0;

        txn(2'b01, 0, ARGS0, 2, 16'd1, 1'b0, 1'b0);
        txn(2'b01, 0, ARGS0, 1, 16'd9, 1'b1, 1'b0);

        // Watchdog: requester 1 granted, generator silent after start.
        req_start = 2'b10;
        at_neg();
        chk("to_ack", 64'(req_ack), 64'd2);
        to_next();
        req_start = 2'b00;
        at_neg();
        chk("to_start", 64'(gen_start), 64'd1);
        chk("to_args", 64'({gen_d, gen_c, gen_b, gen_a}), 64'(ARGS1));
        to_next();
        for (int i = 0; i < 8; i++) begin
            at_neg();
            chk("to_waiting", 64'({rsp_done, rsp_err, gen_reset}), 64'd0);
            to_next();
        end
        at_neg();
        chk("to_done", 64'(rsp_done), 64'd2);
        chk("to_err", 64'(rsp_err), 64'd1);
        chk("to_genrst", 64'(gen_reset), 64'd1);
        to_next();
        at_neg();
        chk("to_idle", 64'({rsp_done, rsp_err, gen_reset, gen_start}), 64'd0);
        to_next();

        // Both held: grants must alternate starting with requester 0.
        txn(2'b11, 0, ARGS0, 3, 16'd20, 1'b0, 1'b1);
        txn(2'b11, 1, ARGS1, 3, 16'd40, 1'b0, 1'b1);
        txn(2'b11, 0, ARGS0, 3, 16'd60, 1'b0, 1'b1);
        txn(2'b11, 1, ARGS1, 3, 16'd80, 1'b0, 1'b0);

        // Reset mid-run with gen_done coinciding: no completion must follow.
        req_start = 2'b01;
        at_neg();
        to_next();
        req_start = 2'b00;
        at_neg();
        to_next();
        gen_valid = 1'b1;
        gen_out0  = 16'd100;
        gen_out1  = 16'd101;
        sb.push_back('{v: 2'b01, o0: 16'd100, o1: 16'd101});
        at_neg();
        chk("mr_fwd_drained", 64'(sb.size()), 64'd0);
        to_next();
        rst       = 1'b1;
        gen_valid = 1'b0;
        gen_done  = 1'b1;
        at_neg();
        chk("mr_reset_cycle", 64'({rsp_valid, rsp_done, gen_start}), 64'd0);
        to_next();
        gen_done = 1'b0;
        at_neg();
        chk_quiet("mr_after");
        to_next();
        rst = 1'b0;
        at_neg();
        chk("mr_no_done", 64'({rsp_done, gen_start, gen_reset}), 64'd0);
        to_next();
        txn(2'b11, 0, ARGS0, 1, 16'd7, 1'b1, 1'b0);

        chk("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
